// File: rtl/barcode_frame_sequencer.sv
// barcode_frame_sequencer: buffers digits in a small FIFO and sends each frame
// as a serial bar stream: start guard, an 11-bit code per digit, stop guard.
// The 11-bit code comes from the external numToBarcodeConverter (conv_num -> conv_bc).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no frame in progress; waiting for a buffered digit
// START  | sending the start guard bars
// LOAD   | one cycle: capture conv_bc, pop the FIFO head, latch its last flag
// DATA   | sending the 11 code bars of the loaded digit, MSB first
// WAIT   | underrun inside a frame; bars paused until a digit arrives
// STOP   | sending the stop guard bars; frame_done follows the final bar
module barcode_frame_sequencer #(
  parameter int                 DEPTH      = 4,
  parameter int                 BIT_CYCLES = 4,
  parameter int                 GUARD_W    = 3,
  parameter logic [GUARD_W-1:0] GUARD_PAT  = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        digit_last,
  output logic        digit_ready,
  output logic [3:0]  conv_num,
  input  logic [10:0] conv_bc,
  output logic        bar_out,
  output logic        bar_valid,
  output logic        bar_strobe,
  output logic        frame_active,
  output logic        frame_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  // Guard bars are sent from the top of the same shift register as code bars.
  localparam logic [10:0] GUARD_WORD = 11'(GUARD_PAT) << (11 - GUARD_W);

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD, S_DATA, S_WAIT, S_STOP} state_t;

  state_t          state, state_nxt;
  logic [4:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [AW:0]     count, count_next;
  logic            push, pop, empty, full;
  logic [3:0]      head_next;
  logic [CW-1:0]   bar_cnt;
  logic [3:0]      bar_idx;
  logic [10:0]     shreg;
  logic            last_flag;
  logic            bar_wrap, phase_last, phase_end;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign digit_ready = !full;
  assign push        = digit_valid && !full;
  assign pop         = (state == S_LOAD);
  assign rd_next     = rd_ptr + AW'(pop);
  assign count_next  = count + (AW+1)'(push) - (AW+1)'(pop);

  assign bar_wrap    = bar_valid && (bar_cnt == CW'(BIT_CYCLES - 1));
  assign phase_last  = (state == S_DATA) ? (bar_idx == 4'd10) : (bar_idx == 4'(GUARD_W - 1));
  assign phase_end   = bar_wrap && phase_last;

  // Head of the FIFO as it will be after this edge; a digit pushed into an
  // otherwise empty FIFO becomes the head directly.
  always_comb begin
    head_next = 4'd0;
    if (count_next != '0) begin
      if (push && (wr_ptr == rd_next)) head_next = digit_in;
      else                             head_next = mem[rd_next][3:0];
    end
  end

  // FIFO storage, written on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {digit_last, digit_in};
  end

  // FIFO pointers, occupancy and the registered converter input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      conv_num <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_next;
      count    <= count_next;
      conv_num <= head_next;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (phase_end) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_DATA;
      S_DATA:  if (phase_end) begin
                 if (last_flag)   state_nxt = S_STOP;
                 else if (!empty) state_nxt = S_LOAD;
                 else             state_nxt = S_WAIT;
               end
      S_WAIT:  if (!empty) state_nxt = S_LOAD;
      S_STOP:  if (phase_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the current state and bar shift register.
  always_comb begin
    bar_valid    = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    bar_out      = bar_valid && shreg[10];
    bar_strobe   = bar_valid && (bar_cnt == '0);
    frame_active = (state != S_IDLE);
  end

  // Bar timing, bar shifting, last-flag capture and the frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt    <= '0;
      bar_idx    <= 4'd0;
      shreg      <= 11'd0;
      last_flag  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (!bar_valid || bar_wrap) bar_cnt <= '0;
      else                        bar_cnt <= bar_cnt + CW'(1);

      if (!bar_valid || phase_end) bar_idx <= 4'd0;
      else if (bar_wrap)           bar_idx <= bar_idx + 4'd1;

      if ((state == S_IDLE) && !empty)                       shreg <= GUARD_WORD;
      else if (state == S_LOAD)                              shreg <= conv_bc;
      else if ((state == S_DATA) && phase_end && last_flag)  shreg <= GUARD_WORD;
      else if (bar_wrap)                                     shreg <= shreg << 1;

      if (state == S_LOAD) last_flag <= mem[rd_ptr][4];

      frame_done <= (state == S_STOP) && phase_end;
    end
  end

endmodule

// File: tb/tb_barcode_frame_sequencer.sv
// Directed bench for barcode_frame_sequencer with a stand-in converter.
module tb_barcode_frame_sequencer;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_valid = 1'b0;
  logic        digit_last = 1'b0;
  logic        digit_ready;
  logic [3:0]  conv_num;
  logic [10:0] conv_bc;
  logic        bar_out, bar_valid, bar_strobe, frame_active, frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit bars[$];
  int strobe_cyc[$];
  int done_cyc[$];
  bit exp_bars[$];
  int hold_err = 0;
  int zero_err = 0;
  int gap = 0;
  int stall = 0;
  bit last_bar = 1'b0;

  // Stand-in for numToBarcodeConverter: any injective 11-bit code works.
  function automatic logic [10:0] bc(input logic [3:0] n);
    return {1'b1, n, ~n, 2'b01};
  endfunction

  assign conv_bc = bc(conv_num);

  barcode_frame_sequencer #(.DEPTH(4), .BIT_CYCLES(BC), .GUARD_W(3), .GUARD_PAT(3'b101)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .digit_last(digit_last), .digit_ready(digit_ready), .conv_num(conv_num),
    .conv_bc(conv_bc), .bar_out(bar_out), .bar_valid(bar_valid), .bar_strobe(bar_strobe),
    .frame_active(frame_active), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bar recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (bar_strobe) begin
      bars.push_back(bar_out);
      strobe_cyc.push_back(cyc);
    end
    if (bar_valid && !bar_strobe && (bar_out !== last_bar)) hold_err++;
    if (bar_valid) last_bar = bar_out;
    if (!bar_valid && bar_out) zero_err++;
    if (frame_active && !bar_valid) gap++;
    if (digit_valid && !digit_ready) stall++;
    if (frame_done) done_cyc.push_back(cyc);
  end

  task automatic exp_guard();
    logic [2:0] g;
    g = 3'b101;
    for (int i = 2; i >= 0; i--) exp_bars.push_back(g[i]);
  endtask

  task automatic exp_digit(input logic [3:0] d);
    logic [10:0] c;
    c = bc(d);
    for (int i = 10; i >= 0; i--) exp_bars.push_back(c[i]);
  endtask

  // -1: match, -2: length differs, else index of first differing bar.
  function automatic int bars_diff(input int base);
    if (bars.size() - base != exp_bars.size()) return -2;
    for (int i = 0; i < exp_bars.size(); i++)
      if (bars[base + i] !== exp_bars[i]) return i;
    return -1;
  endfunction

  int push_cyc;

  task automatic push(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    digit_in = d; digit_last = last; digit_valid = 1'b1;
    while (!digit_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!digit_ready) begin
      errors++;
      $display("FAIL push_timeout: digit %0d never accepted, digit_ready=%0b required 1", d, digit_ready);
    end
    push_cyc = cyc;
  endtask

  task automatic release_in();
    @(negedge clk);
    digit_valid = 1'b0;
    digit_last = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string name);
    int k;
    k = 0;
    while (done_cyc.size() == n0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cyc.size() != n0 + 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d frame_done pulses, required 1", name, done_cyc.size() - n0);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bar_valid, bar_out, bar_strobe, frame_active, frame_done, digit_ready, conv_num} !== {6'b000001, 4'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b out=%0b strobe=%0b active=%0b done=%0b ready=%0b num=%0d, required 0 0 0 0 0 1 0",
               bar_valid, bar_out, bar_strobe, frame_active, frame_done, digit_ready, conv_num);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (frame_active !== 1'b0 || bars.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: active=%0b bars=%0d, required 0 and 0", frame_active, bars.size());
    end
  endtask

  task automatic test_single();
    int b0, s0, d0, g0, h0, dd;
    b0 = bars.size(); s0 = strobe_cyc.size(); d0 = done_cyc.size(); g0 = gap; h0 = hold_err;
    push(4'd5, 1'b1);
    release_in();
    wait_done(d0, "single");
    exp_bars.delete();
    exp_guard(); exp_digit(4'd5); exp_guard();
    dd = bars_diff(b0);
    checks++;
    if (dd != -1) begin
      errors++;
      $display("FAIL single_bars: got %0d bars (diff code %0d), required %0d matching bars", bars.size() - b0, dd, exp_bars.size());
    end
    checks++;
    if (strobe_cyc[s0] != push_cyc + 2) begin
      errors++;
      $display("FAIL single_first_bar: got cycle %0d, required %0d", strobe_cyc[s0], push_cyc + 2);
    end
    checks++;
    if (strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[s0] != 16 * BC + 1) begin
      errors++;
      $display("FAIL single_span: got %0d cycles, required %0d", strobe_cyc[strobe_cyc.size()-1] - strobe_cyc[s0], 16 * BC + 1);
    end
    checks++;
    if (done_cyc[d0] != strobe_cyc[strobe_cyc.size()-1] + BC) begin
      errors++;
      $display("FAIL single_done_time: got cycle %0d, required %0d", done_cyc[d0], strobe_cyc[strobe_cyc.size()-1] + BC);
    end
    checks++;
    if (gap - g0 != 1 || hold_err != h0) begin
      errors++;
      $display("FAIL single_gaps: got gap=%0d hold_err=%0d, required 1 and 0", gap - g0, hold_err - h0);
    end
  endtask

  task automatic test_multi();
    int b0, d0, g0, dd;
    b0 = bars.size(); d0 = done_cyc.size(); g0 = gap;
    push(4'd0, 1'b0);
    push(4'd9, 1'b0);
    push(4'd15, 1'b1);
    release_in();
    wait_done(d0, "multi");
    exp_bars.delete();
    exp_guard(); exp_digit(4'd0); exp_digit(4'd9); exp_digit(4'd15); exp_guard();
    dd = bars_diff(b0);
    checks++;
    if (dd != -1) begin
      errors++;
      $display("FAIL multi_bars: got %0d bars (diff code %0d), required %0d matching bars", bars.size() - b0, dd, exp_bars.size());
    end
    checks++;
    if (gap - g0 != 3) begin
      errors++;
      $display("FAIL multi_gaps: got %0d invalid cycles in frame, required 3", gap - g0);
    end
  endtask

  task automatic test_back_to_back();
    int b0, d0, st0, dd;
    logic [3:0] ds [6];
    ds = '{4'd2, 4'd11, 4'd4, 4'd13, 4'd6, 4'd1};
    b0 = bars.size(); d0 = done_cyc.size(); st0 = stall;
    for (int i = 0; i < 6; i++) push(ds[i], i == 5);
    release_in();
    wait_done(d0, "backpressure");
    exp_bars.delete();
    exp_guard();
    for (int i = 0; i < 6; i++) exp_digit(ds[i]);
    exp_guard();
    dd = bars_diff(b0);
    checks++;
    if (dd != -1) begin
      errors++;
      $display("FAIL backpressure_bars: got %0d bars (diff code %0d), required %0d matching bars", bars.size() - b0, dd, exp_bars.size());
    end
    checks++;
    if (stall - st0 == 0) begin
      errors++;
      $display("FAIL backpressure_ready: got 0 stalled cycles, required digit_ready low at full");
    end
  endtask

  task automatic test_underrun();
    int b0, d0, g0, z0, dd;
    b0 = bars.size(); d0 = done_cyc.size(); g0 = gap; z0 = zero_err;
    push(4'd3, 1'b0);
    release_in();
    repeat (100) @(negedge clk);
    push(4'd7, 1'b1);
    release_in();
    wait_done(d0, "underrun");
    exp_bars.delete();
    exp_guard(); exp_digit(4'd3); exp_digit(4'd7); exp_guard();
    dd = bars_diff(b0);
    checks++;
    if (dd != -1) begin
      errors++;
      $display("FAIL underrun_bars: got %0d bars (diff code %0d), required %0d matching bars", bars.size() - b0, dd, exp_bars.size());
    end
    checks++;
    if (gap - g0 != 47 || zero_err != z0) begin
      errors++;
      $display("FAIL underrun_wait: got %0d invalid in-frame cycles, zero_err=%0d, required 47 and 0", gap - g0, zero_err - z0);
    end
  endtask

  task automatic test_simul_push_pop();
    int b0, d0, loads, k, dd;
    b0 = bars.size(); d0 = done_cyc.size();
    push(4'd8, 1'b0);
    push(4'd1, 1'b0);
    push(4'd2, 1'b0);
    push(4'd3, 1'b0);
    release_in();
    loads = 0; k = 0;
    while (loads < 2 && k < 500) begin
      @(negedge clk);
      if (frame_active && !bar_valid) loads++;
      k++;
    end
    checks++;
    if (loads != 2 || digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: got loads=%0d ready=%0b, required 2 and 1", loads, digit_ready);
    end
    digit_in = 4'd4; digit_last = 1'b0; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
    checks++;
    if (digit_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_occupancy: got digit_ready=%0b after push+pop, required 1", digit_ready);
    end
    push(4'd5, 1'b1);
    release_in();
    checks++;
    if (digit_ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: got digit_ready=%0b after one more push, required 0", digit_ready);
    end
    wait_done(d0, "simul");
    exp_bars.delete();
    exp_guard();
    exp_digit(4'd8); exp_digit(4'd1); exp_digit(4'd2); exp_digit(4'd3); exp_digit(4'd4); exp_digit(4'd5);
    exp_guard();
    dd = bars_diff(b0);
    checks++;
    if (dd != -1) begin
      errors++;
      $display("FAIL simul_bars: got %0d bars (diff code %0d), required %0d matching bars", bars.size() - b0, dd, exp_bars.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int b0, d0, k, b1;
    b0 = bars.size(); d0 = done_cyc.size();
    push(4'd9, 1'b1);
    release_in();
    k = 0;
    while (bars.size() < b0 + 6 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bar_valid !== 1'b0 || frame_active !== 1'b0 || digit_ready !== 1'b1 || bar_out !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%0b active=%0b ready=%0b out=%0b, required 0 0 1 0",
               bar_valid, frame_active, digit_ready, bar_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b1 = bars.size();
    repeat (80) @(negedge clk);
    checks++;
    if (done_cyc.size() != d0 || bars.size() != b1 || frame_active !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: got done=%0d new bars=%0d active=%0b, required 0 0 0",
               done_cyc.size() - d0, bars.size() - b1, frame_active);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_back_to_back();
    test_underrun();
    test_simul_push_pop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
